// File: rtl/sound_pkg.sv
// rtl/sound_pkg.sv - shared types and helpers for the speaker arbiter
package sound_pkg;

    localparam int DUR_W = 24;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        SCORE = 2'd1,
        JUMP  = 2'd2,
        OVER  = 2'd3
    } owner_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        PLAY,
        GAP
    } arb_state_t;

    // Pending-flag bit for a source: bit0 score, bit1 jump, bit2 over.
    function automatic logic [2:0] src_bit(input owner_t o);
        case (o)
            SCORE:   return 3'b001;
            JUMP:    return 3'b010;
            OVER:    return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/sound_timer.sv
// rtl/sound_timer.sv - loadable down-counter that parks at zero
module sound_timer
    import sound_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [DUR_W-1:0] load_value,
    output logic [DUR_W-1:0] value,
    output logic             zero
);

    assign zero = (value == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (!zero) begin
            value <= value - DUR_W'(1);
        end
    end

endmodule

// File: rtl/sound_arbiter.sv
// rtl/sound_arbiter.sv - grants the speaker to one of three sound players
module sound_arbiter
    import sound_pkg::*;
#(
    parameter int OVER_CYCLES  = 6_400_000,
    parameter int JUMP_CYCLES  = 5_000_000,
    parameter int SCORE_CYCLES = 2_500_000,
    parameter int GAP_CYCLES   = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_over,
    input  logic       req_jump,
    input  logic       req_score,
    input  logic       wave_over,
    input  logic       wave_jump,
    input  logic       wave_score,
    input  logic       mute,
    output logic       start_over,
    output logic       start_jump,
    output logic       start_score,
    output logic [1:0] owner,
    output logic       busy,
    output logic       audio_out
);

    localparam int DUR_MAX = (1 << DUR_W) - 1;

    if (OVER_CYCLES < 1 || OVER_CYCLES > DUR_MAX || JUMP_CYCLES < 1 || JUMP_CYCLES > DUR_MAX ||
        SCORE_CYCLES < 1 || SCORE_CYCLES > DUR_MAX || GAP_CYCLES < 0 || GAP_CYCLES > DUR_MAX) begin : g_bad_param
        $error("sound_arbiter: duration parameter out of range");
    end

    // Counter holds N-1 so that reaching zero marks the last cycle of the phase.
    localparam logic [DUR_W-1:0] OVER_M1  = DUR_W'(OVER_CYCLES - 1);
    localparam logic [DUR_W-1:0] JUMP_M1  = DUR_W'(JUMP_CYCLES - 1);
    localparam logic [DUR_W-1:0] SCORE_M1 = DUR_W'(SCORE_CYCLES - 1);
    localparam logic [DUR_W-1:0] GAP_M1   = (GAP_CYCLES == 0) ? '0 : DUR_W'(GAP_CYCLES - 1);

    arb_state_t       state, state_n;
    owner_t           owner_q, owner_n, grant, hi;
    logic [2:0]       pending, pending_n, owner_mask, clear_mask;
    logic             timer_load, timer_zero, wave_sel;
    logic [DUR_W-1:0] load_value, timer_value;

    sound_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (load_value),
        .value      (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        hi = NONE;
        if (pending[2])      hi = OVER;
        else if (pending[1]) hi = JUMP;
        else if (pending[0]) hi = SCORE;
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner_q;
        grant      = NONE;
        timer_load = 1'b0;
        load_value = '0;
        case (state)
            IDLE:  grant = hi;
            START: begin
                state_n    = PLAY;
                timer_load = 1'b1;
                case (owner_q)
                    OVER:    load_value = OVER_M1;
                    JUMP:    load_value = JUMP_M1;
                    SCORE:   load_value = SCORE_M1;
                    default: load_value = '0;
                endcase
            end
            PLAY: begin
                if (hi > owner_q) begin
                    grant = hi;
                end else if (timer_zero) begin
                    owner_n = NONE;
                    if (GAP_CYCLES == 0) begin
                        state_n = IDLE;
                    end else begin
                        state_n    = GAP;
                        timer_load = 1'b1;
                        load_value = GAP_M1;
                    end
                end
            end
            GAP:     if (timer_zero) state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (grant != NONE) begin
            state_n = START;
            owner_n = grant;
        end
        // Re-requests of the playing source are dropped; an OVER grant flushes the queue.
        owner_mask = (state == START || state == PLAY) ? src_bit(owner_q) : 3'b000;
        clear_mask = (grant == OVER) ? 3'b111 : src_bit(grant);
        pending_n  = (pending | ({req_over, req_jump, req_score} & ~owner_mask)) & ~clear_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            owner_q <= NONE;
            pending <= '0;
        end else begin
            state   <= state_n;
            owner_q <= owner_n;
            pending <= pending_n;
        end
    end

    always_comb begin
        case (owner_q)
            OVER:    wave_sel = wave_over;
            JUMP:    wave_sel = wave_jump;
            SCORE:   wave_sel = wave_score;
            default: wave_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            audio_out <= 1'b0;
        end else if (state == START || state == PLAY) begin
            audio_out <= !mute && wave_sel;
        end else begin
            audio_out <= 1'b0;
        end
    end

    assign start_over  = (state == START) && (owner_q == OVER);
    assign start_jump  = (state == START) && (owner_q == JUMP);
    assign start_score = (state == START) && (owner_q == SCORE);
    assign owner       = owner_q;
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_sound_arbiter.sv
// tb/tb_sound_arbiter.sv - scoreboard bench for sound_arbiter
module tb_sound_arbiter;

    logic       clk, rst_n;
    logic       req_over, req_jump, req_score;
    logic       wave_over, wave_jump, wave_score, mute;
    logic       start_over, start_jump, start_score;
    logic [1:0] owner;
    logic       busy, audio_out;

    int         total = 0;
    int         bad = 0;
    logic [1:0] exp_q[$];

    sound_arbiter #(
        .OVER_CYCLES  (40),
        .JUMP_CYCLES  (100),
        .SCORE_CYCLES (100),
        .GAP_CYCLES   (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_over    (req_over),
        .req_jump    (req_jump),
        .req_score   (req_score),
        .wave_over   (wave_over),
        .wave_jump   (wave_jump),
        .wave_score  (wave_score),
        .mute        (mute),
        .start_over  (start_over),
        .start_jump  (start_jump),
        .start_score (start_score),
        .owner       (owner),
        .busy        (busy),
        .audio_out   (audio_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        wave_over = 1'b0; wave_jump = 1'b0; wave_score = 1'b0;
        forever begin
            @(negedge clk);
            wave_over  = 1'($urandom);
            wave_jump  = 1'($urandom);
            wave_score = 1'($urandom);
        end
    end

    // Start-pulse scoreboard consumer
    initial begin
        logic [2:0] s, prev_s;
        logic [1:0] code, want;
        prev_s = 3'b000;
        forever begin
            @(negedge clk);
            s = {start_over, start_jump, start_score};
            if (rst_n && s != 3'b000) begin
                code = start_over ? 2'd3 : (start_jump ? 2'd2 : 2'd1);
                total++;
                if ($countones(s) != 1) begin
                    bad++; $display("FAIL start_onehot got=%b want=onehot", s);
                end
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL start_unexpected got=%0d want=none", code);
                end else begin
                    want = exp_q.pop_front();
                    if (code !== want) begin
                        bad++; $display("FAIL start_source got=%0d want=%0d", code, want);
                    end
                end
                total++;
                if ((s & prev_s) != 3'b000) begin
                    bad++; $display("FAIL start_width got=%b prev=%b want=single_cycle", s, prev_s);
                end
            end
            prev_s = rst_n ? s : 3'b000;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 1000) begin tick(); n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle_timeout busy=%0b want=0", tag, busy); end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; req_over = 1'b0; req_jump = 1'b0; req_score = 1'b0; mute = 1'b0;
        #2 rst_n = 1'b0;
        tick(); tick();
        total++;
        if ({owner, busy, audio_out, start_over, start_jump, start_score} !== 7'd0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0000000",
                            {owner, busy, audio_out, start_over, start_jump, start_score});
        end
        rst_n = 1'b1;
        tick(); tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL reset_release_busy got=%0b want=0", busy); end
    endtask

    task automatic test_single_jump();
        int cnt, gap;
        req_jump = 1'b1; exp_q.push_back(2'd2);
        tick(); req_jump = 1'b0;
        total++;
        if (start_jump !== 1'b0) begin bad++; $display("FAIL jump_start_early got=%0b want=0", start_jump); end
        tick();
        total++;
        if (start_jump !== 1'b1 || owner !== 2'd2) begin
            bad++; $display("FAIL jump_start got=%0b/%0d want=1/2", start_jump, owner);
        end
        cnt = 1;
        while (owner == 2'd2 && cnt < 300) begin
            tick();
            if (owner == 2'd2) begin
                cnt++;
                total++;
                if (audio_out !== wave_jump) begin
                    bad++; $display("FAIL jump_audio got=%0b want=%0b at=%0d", audio_out, wave_jump, cnt);
                end
            end
        end
        total++;
        if (cnt != 101) begin bad++; $display("FAIL jump_owner_len got=%0d want=101", cnt); end
        total++;
        if (audio_out !== wave_jump || busy !== 1'b1) begin
            bad++; $display("FAIL jump_tail got=%0b/%0b want=%0b/1", audio_out, busy, wave_jump);
        end
        gap = 0;
        while (busy && gap < 100) begin
            tick(); gap++;
            total++;
            if (audio_out !== 1'b0) begin bad++; $display("FAIL gap_audio got=%0b want=0", audio_out); end
        end
        total++;
        if (gap != 10) begin bad++; $display("FAIL jump_gap_len got=%0d want=10", gap); end
    endtask

    task automatic test_simultaneous();
        req_over = 1'b1; req_jump = 1'b1; req_score = 1'b1; exp_q.push_back(2'd3);
        tick(); req_over = 1'b0; req_jump = 1'b0; req_score = 1'b0;
        tick();
        total++;
        if ({start_over, start_jump, start_score} !== 3'b100 || owner !== 2'd3) begin
            bad++; $display("FAIL simul_grant got=%b/%0d want=100/3", {start_over, start_jump, start_score}, owner);
        end
        wait_idle("simul");
        repeat (20) tick();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL simul_flags_cleared busy=%0b want=0", busy); end
    endtask

    task automatic test_preempt();
        int cnt;
        req_score = 1'b1; exp_q.push_back(2'd1);
        tick(); req_score = 1'b0;
        tick();
        total++;
        if (owner !== 2'd1) begin bad++; $display("FAIL preempt_score_owner got=%0d want=1", owner); end
        repeat (30) tick();
        req_jump = 1'b1; exp_q.push_back(2'd2);
        tick(); req_jump = 1'b0;
        total++;
        if (owner !== 2'd1) begin bad++; $display("FAIL preempt_before got=%0d want=1", owner); end
        tick();
        total++;
        if (start_jump !== 1'b1 || owner !== 2'd2) begin
            bad++; $display("FAIL preempt_start got=%0b/%0d want=1/2", start_jump, owner);
        end
        tick();
        total++;
        if (audio_out !== wave_jump) begin bad++; $display("FAIL preempt_audio got=%0b want=%0b", audio_out, wave_jump); end
        cnt = 2;
        while (owner == 2'd2 && cnt < 300) begin tick(); if (owner == 2'd2) cnt++; end
        total++;
        if (cnt != 101) begin bad++; $display("FAIL preempt_jump_len got=%0d want=101", cnt); end
        wait_idle("preempt");
        repeat (20) tick();
    endtask

    task automatic test_same_source();
        int cnt, g;
        req_jump = 1'b1; exp_q.push_back(2'd2);
        tick(); req_jump = 1'b0;
        tick();
        cnt = 1;
        for (int i = 0; i < 400; i++) begin
            if (i == 20) req_jump = 1'b1;
            if (i == 40) begin req_score = 1'b1; exp_q.push_back(2'd1); end
            tick();
            req_jump = 1'b0; req_score = 1'b0;
            if (owner == 2'd2) cnt++;
            else break;
        end
        total++;
        if (cnt != 101) begin bad++; $display("FAIL same_jump_len got=%0d want=101", cnt); end
        g = 0;
        while (owner == 2'd0 && g < 100) begin tick(); g++; end
        total++;
        if (g != 11 || start_score !== 1'b1) begin
            bad++; $display("FAIL queued_score_delay got=%0d/%0b want=11/1", g, start_score);
        end
        wait_idle("same");
    endtask

    task automatic test_mute();
        int cnt;
        req_score = 1'b1; exp_q.push_back(2'd1);
        tick(); req_score = 1'b0;
        tick();
        cnt = 1;
        repeat (10) begin tick(); if (owner == 2'd1) cnt++; end
        mute = 1'b1;
        repeat (6) begin
            tick();
            if (owner == 2'd1) cnt++;
            total++;
            if (audio_out !== 1'b0 || owner !== 2'd1) begin
                bad++; $display("FAIL mute_audio got=%0b/%0d want=0/1", audio_out, owner);
            end
        end
        mute = 1'b0;
        tick();
        if (owner == 2'd1) cnt++;
        total++;
        if (audio_out !== wave_score) begin bad++; $display("FAIL unmute_audio got=%0b want=%0b", audio_out, wave_score); end
        while (owner == 2'd1 && cnt < 300) begin tick(); if (owner == 2'd1) cnt++; end
        total++;
        if (cnt != 101) begin bad++; $display("FAIL mute_len got=%0d want=101", cnt); end
        wait_idle("mute");
    endtask

    task automatic test_reset_mid();
        req_jump = 1'b1; exp_q.push_back(2'd2);
        tick(); req_jump = 1'b0;
        repeat (20) tick();
        req_score = 1'b1;
        tick(); req_score = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({owner, busy, audio_out, start_over, start_jump, start_score} !== 7'd0) begin
            bad++; $display("FAIL async_reset got=%b want=0000000",
                            {owner, busy, audio_out, start_over, start_jump, start_score});
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (30) begin
            tick();
            total++;
            if ({owner, busy, start_over, start_jump, start_score} !== 6'd0) begin
                bad++; $display("FAIL post_reset_idle got=%b want=000000",
                                {owner, busy, start_over, start_jump, start_score});
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_jump();
        test_simultaneous();
        test_preempt();
        test_same_source();
        test_mute();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL missing_starts got=%0d want=0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sound_arbiter.md
# sound_arbiter

Schedules the shared speaker output between the game's three square-wave sound players (game-over, jump, score milestone). Latches one-cycle sound requests from game logic, issues a one-cycle start pulse to the chosen player, routes that player's wave to the single speaker pin for a fixed duration, and inserts a silent gap before the next sound. Sits between the game FSM and the sound players, directly feeding the top-level audio pin.

## Interface
- `OVER_CYCLES`, default 6_400_000: game-over sound duration in clocks (32 × 200_000); must be ≥ 1.
- `JUMP_CYCLES`, default 5_000_000: jump sound duration in clocks; must be ≥ 1.
- `SCORE_CYCLES`, default 2_500_000: score sound duration in clocks; must be ≥ 1.
- `GAP_CYCLES`, default 500_000: forced silence after a sound completes normally; 0 allowed (GAP skipped).
- `clk` in 1: 50 MHz system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_over` in 1: one-cycle request for the game-over sound.
- `req_jump` in 1: one-cycle request for the jump sound.
- `req_score` in 1: one-cycle request for the score sound.
- `wave_over` in 1: game-over player wave.
- `wave_jump` in 1: jump player wave.
- `wave_score` in 1: score player wave.
- `mute` in 1: level; forces the speaker low without affecting sequencing.
- `start_over` out 1: one-cycle start pulse to the game-over player.
- `start_jump` out 1: one-cycle start pulse to the jump player.
- `start_score` out 1: one-cycle start pulse to the score player.
- `owner` out 2: current grant. 0 NONE, 1 SCORE, 2 JUMP, 3 OVER.
- `busy` out 1: high whenever the state is not IDLE.
- `audio_out` out 1: registered speaker output.

## Operation
- Pending flags: one per source. Set by the source's `req_*`; cleared when that source is granted. A request for the source that currently owns the speaker is dropped.
- Priority, fixed: OVER > JUMP > SCORE.
- Granting OVER clears all pending flags; nothing queued before game over plays after it.
- States:
  - IDLE: if any flag is pending, grant the highest one → START.
  - START: the granted `start_*` is high; counter loaded with that source's duration → PLAY.
  - PLAY: count down. At 0 → GAP, or IDLE if `GAP_CYCLES` = 0. A pending flag of higher priority than `owner` preempts: grant it → START, with no gap.
  - GAP: `owner` = NONE; count `GAP_CYCLES` → IDLE.
- A preempted sound is abandoned, not resumed.
- Equal or lower-priority pending flags wait until IDLE.
- `audio_out` is registered:
  - `audio_out` ← `!mute` & `wave_<owner>` when in PLAY or START.
  - `audio_out` ← 0 otherwise.
- Counter: 24-bit unsigned down-counter, no wrap. Parameters must fit in 24 bits; this is checked at elaboration.

## Timing
- Reset (asynchronous): state IDLE, all pending flags 0, counter 0. Outputs `owner` = 0, `busy` = 0, `audio_out` = 0, all `start_*` = 0.
- Request sampled high at edge k:
  - pending flag set at edge k.
  - START with `owner` and `start_*` = 1 at edge k+1.
  - PLAY with `start_*` = 0 at edge k+2.
- Request arriving in IDLE → start pulse 1 cycle later; latency 2 edges from request to PLAY.
- PLAY lasts exactly DUR cycles, then GAP lasts exactly `GAP_CYCLES` cycles.
- Preemption: a higher-priority request sampled at edge k during PLAY → START at edge k+1. `audio_out` switches source at edge k+2.
- Simultaneous requests in one cycle: all flags set; the highest is granted first.
- A request arriving on the same edge its source is granted is dropped (flag cleared).
- `start_*` is never high for more than one cycle, and at most one `start_*` is high at a time.
- `rst_n` asserted mid-sound: immediate return to reset values; no start pulse is issued on release.

## Structure
- Shared package `sound_pkg`:
  - `owner_t` enum (NONE/SCORE/JUMP/OVER, 2 bits).
  - `arb_state_t` enum (IDLE/START/PLAY/GAP).
  - `DUR_W` = 24.
- Sub-module `sound_timer`: loadable 24-bit down-counter with `load`, `value`, and `zero` flag. Shared by the PLAY and GAP states.
- Everything else lives in `sound_arbiter`.

## Test plan
- Reset then single `req_jump` pulse (`JUMP_CYCLES`=100, `GAP_CYCLES`=10):
  - `start_jump` high exactly 1 cycle, 1 cycle after the request.
  - `owner` = 2 for 101 cycles.
  - `audio_out` follows `wave_jump` with 1-cycle lag.
  - `busy` falls after the gap.
- `req_score`, `req_jump`, `req_over` in the same cycle → only `start_over`; the other two flags are cleared; `owner` = 3; returns to IDLE afterwards.
- `req_score` playing, `req_jump` at cycle 30 of 100 → preempt: `start_jump` pulse, no gap, `owner` 1→2, score never resumes.
- `req_jump` during jump PLAY → ignored (no start pulse, duration not extended). `req_score` during jump → plays after jump + gap.
- `mute` = 1 during PLAY → `audio_out` = 0 while `owner` and the counters are unchanged. Release `mute` → wave resumes the next cycle.
- `rst_n` low mid-PLAY with pending `req_score` → all outputs 0 asynchronously. After release: IDLE, no start pulse.
